// File: rtl/cache_trace_sequencer.sv
// Replays a trace of addresses through a cache: fetch each reference, run a
// search phase (sample hit/miss), then an update phase, counting as it goes.
module cache_trace_sequencer #(
    parameter int IDX_W  = 16,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  trace_len,
    input  logic              hold,
    output logic [IDX_W-1:0]  mem_idx,
    input  logic [ADDR_W-1:0] mem_data,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_state,
    input  logic              cache_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  ref_count,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEARCH,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  mem_idx_q, mem_idx_d;
    logic [IDX_W-1:0]  idx_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  ref_q, ref_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [CNT_W-1:0]  miss_q, miss_d;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign idx_inc = idx_q + IDX_W'(1);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        mem_idx_d = mem_idx_q;
        addr_d    = addr_q;
        ref_d     = ref_q;
        hit_d     = hit_q;
        miss_d    = miss_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ref_d  = '0;
                    hit_d  = '0;
                    miss_d = '0;
                    if (trace_len != '0) begin
                        len_d   = trace_len;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                // idx is frozen under hold, so remembering it here is harmless
                mem_idx_d = idx_q;
                if (!hold) begin
                    addr_d  = mem_data;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (!hold) begin
                    if (cache_hit) hit_d = sat_inc(hit_q);
                    else           miss_d = sat_inc(miss_q);
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (!hold) begin
                    ref_d   = sat_inc(ref_q);
                    idx_d   = idx_inc;
                    state_d = (idx_inc == len_q) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            len_q     <= '0;
            mem_idx_q <= '0;
            addr_q    <= '0;
            ref_q     <= '0;
            hit_q     <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            len_q     <= len_d;
            mem_idx_q <= mem_idx_d;
            addr_q    <= addr_d;
            ref_q     <= ref_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
        end
    end

    // Live index during FETCH so the combinational trace read lands this cycle.
    assign mem_idx     = (state_q == S_FETCH) ? idx_q : mem_idx_q;
    assign cache_addr  = addr_q;
    assign cache_state = (state_q == S_UPDATE);
    assign busy        = (state_q == S_FETCH) || (state_q == S_SEARCH) || (state_q == S_UPDATE);
    assign done        = (state_q == S_DONE);
    assign ref_count   = ref_q;
    assign hit_count   = hit_q;
    assign miss_count  = miss_q;

endmodule

// File: tb/tb_cache_trace_sequencer.sv
// Randomized bench for cache_trace_sequencer: trace ROM plus an odd-address-hits
// cache stand-in, checked against timing/count formulas derived from the trace.
module tb_cache_trace_sequencer;

    localparam int IDX_W  = 8;
    localparam int ADDR_W = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W-1:0]  trace_len = '0;
    logic              hold = 1'b0;
    logic [IDX_W-1:0]  mem_idx;
    logic [ADDR_W-1:0] mem_data;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_state;
    logic              cache_hit;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  ref_count;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    logic [ADDR_W-1:0] trace_mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    cache_trace_sequencer #(
        .IDX_W (IDX_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .trace_len  (trace_len),
        .hold       (hold),
        .mem_idx    (mem_idx),
        .mem_data   (mem_data),
        .cache_addr (cache_addr),
        .cache_state(cache_state),
        .cache_hit  (cache_hit),
        .busy       (busy),
        .done       (done),
        .ref_count  (ref_count),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    assign mem_data  = trace_mem[mem_idx];
    assign cache_hit = cache_addr[0];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic fill_trace(input bit all_odd);
        for (int i = 0; i < 256; i++)
            trace_mem[i] = 16'($urandom) | (all_odd ? 16'd1 : 16'd0);
    endtask

    // One replay of n references; hold is forced in [hold_from, hold_from+hold_len)
    // and otherwise raised at random; start is re-pulsed in cycle restart_cyc.
    task automatic do_run(input string tag, input int n, input int hold_pct,
                          input int hold_from, input int hold_len, input int restart_cyc);
        int c, holds, busy_cyc, k, done_cyc, exp_hit, exp_miss, overlap;
        bit prev_cs;
        holds = 0; busy_cyc = 0; k = 0; done_cyc = -1; overlap = 0; prev_cs = 1'b0;
        exp_hit = 0; exp_miss = 0;
        for (int i = 0; i < n; i++) begin
            if (trace_mem[i][0]) exp_hit++;
            else                 exp_miss++;
        end
        @(posedge clk); #1;
        start = 1'b1; trace_len = IDX_W'(n);
        @(posedge clk); #1;
        start = 1'b0; trace_len = IDX_W'($urandom);
        c = 1;
        while (done_cyc < 0 && c <= 2000) begin
            hold  = (c >= hold_from && c < hold_from + hold_len) || ($urandom_range(99) < hold_pct);
            start = (c == restart_cyc);
            if (c == restart_cyc) trace_len = IDX_W'(2);
            @(negedge clk);
            if (busy && done) overlap++;
            if (busy) begin
                busy_cyc++;
                if (hold) holds++;
            end
            if (cache_state && !prev_cs) begin
                check({tag, "_addr"}, 32'(cache_addr), 32'(trace_mem[k & 255]));
                check({tag, "_memidx"}, 32'(mem_idx), 32'(k));
                k++;
            end
            prev_cs = cache_state;
            if (done) done_cyc = c;
            @(posedge clk); #1;
            c++;
        end
        hold = 1'b0; start = 1'b0;
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(3 * n + holds + 1));
        check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(3 * n + holds));
        check({tag, "_updates"}, 32'(k), 32'(n));
        check({tag, "_overlap"}, 32'(overlap), 32'd0);
        check({tag, "_ref"}, 32'(ref_count), 32'(sat(n)));
        check({tag, "_hit"}, 32'(hit_count), 32'(sat(exp_hit)));
        check({tag, "_miss"}, 32'(miss_count), 32'(sat(exp_miss)));
        check({tag, "_done_low"}, 32'(done), 32'd0);
        $display("run %s: n=%0d holds=%0d done@%0d ref=%0d hit=%0d miss=%0d",
                 tag, n, holds, done_cyc, ref_count, hit_count, miss_count);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_memidx"}, 32'(mem_idx), 32'd0);
        check({tag, "_addr"}, 32'(cache_addr), 32'd0);
        check({tag, "_cstate"}, 32'(cache_state), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_cnts"}, {20'd0, ref_count, hit_count, miss_count}, 32'd0);
    endtask

    initial begin
        int dones;
        fill_trace(1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;

        // Hits on references 1 and 3 -> done in cycle 13
        trace_mem[0] = 16'h0002; trace_mem[1] = 16'h0005;
        trace_mem[2] = 16'h0008; trace_mem[3] = 16'h0007;
        do_run("len4", 4, 0, 0, 0, 0);

        do_run("len0", 0, 0, 0, 0, 0);

        // Hold across the second SEARCH (cycles 5 and 6) -> done in cycle 12
        fill_trace(1'b0);
        do_run("len3_hold", 3, 0, 5, 2, 0);

        do_run("restart", 5, 0, 0, 0, 5);

        // Reset in the UPDATE of reference 2 of 5 (cycle 6)
        fill_trace(1'b0);
        @(posedge clk); #1 start = 1'b1; trace_len = IDX_W'(5);
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("pre_rst_update", 32'(cache_state), 32'd1);
        rst = 1'b1;
        #1 check_all_zero("mid_rst");
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("post_rst_idle", 32'(dones), 32'd0);
        do_run("after_rst", 2, 0, 0, 0, 0);

        fill_trace(1'b1);
        do_run("sat20", 20, 0, 0, 0, 0);

        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(0, 20);
            fill_trace(1'b0);
            do_run($sformatf("rand%0d", r), n, $urandom_range(0, 30), 0, 0,
                   ($urandom_range(0, 1) != 0 && n > 2) ? $urandom_range(2, 3 * n - 1) : 0);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_trace_sequencer.md
# cache_trace_sequencer

Controller that replays an address trace through the cache simulator. It steps a trace-memory index, latches each reference, and drives the cache's search/update phase input. It samples the hit flag and keeps reference, hit and miss counts. It sits between the trace ROM and the `cache` instance, so the bench only has to pulse `start` and wait for `done`.

## Interface
- `IDX_W`, default 16: width of the trace index and of `trace_len`.
- `ADDR_W`, default 32: width of a trace reference / cache address.
- `CNT_W`, default 16: width of the hit/miss/reference counters.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a replay; sampled only in IDLE.
- `trace_len`  in  IDX_W  number of references to replay; sampled on accepted `start`.
- `hold`  in  1  stall; freezes FETCH/SEARCH/UPDATE while high.
- `mem_idx`  out  IDX_W  trace memory read index.
- `mem_data`  in  ADDR_W  trace memory word at `mem_idx`; combinational read, valid in the same cycle.
- `cache_addr`  out  ADDR_W  reference presented to the cache.
- `cache_state`  out  1  cache phase: 0 = search, 1 = update.
- `cache_hit`  in  1  cache hit flag; valid during SEARCH.
- `busy`  out  1  high in FETCH/SEARCH/UPDATE.
- `done`  out  1  one-cycle pulse in DONE.
- `ref_count`  out  CNT_W  references completed.
- `hit_count`  out  CNT_W  hits counted.
- `miss_count`  out  CNT_W  misses counted.

## Operation
- FSM states: IDLE, FETCH, SEARCH, UPDATE, DONE.
- IDLE:
  - On `start`=1 with `trace_len`≠0: latch `trace_len`, clear idx and all counters, then go to FETCH.
  - On `start`=1 with `trace_len`=0: clear counters, then go to DONE.
- FETCH:
  - `mem_idx`=idx.
  - `cache_addr` register loads `mem_data` at the end of the cycle.
  - Next state is SEARCH.
- SEARCH:
  - `cache_state`=0 and `cache_addr` stable.
  - At the end of the cycle: if `cache_hit`, increment `hit_count`; otherwise increment `miss_count`.
  - Next state is UPDATE.
- UPDATE:
  - `cache_state`=1 for one cycle, letting the cache allocate/refresh.
  - At the end of the cycle: increment `ref_count` and idx.
  - If idx+1 == latched length, go to DONE; otherwise go to FETCH.
- DONE: `done`=1, then go to IDLE. Counters hold their values until the next accepted `start`.
- `hold`=1 in FETCH/SEARCH/UPDATE:
  - State, idx, counters and `cache_addr` are frozen, and no counter increments.
  - `cache_state` keeps its current value.
  - `hold` is ignored in IDLE and DONE.
- `start` in any state other than IDLE is ignored; the in-flight length and counters are untouched.
- All counters saturate at 2^CNT_W−1 and never wrap.
- idx is IDX_W bits wide. `trace_len` = 2^IDX_W−1 replays indices 0 to 2^IDX_W−2 with no idx wrap.
- `mem_idx` outside FETCH holds the last value driven.
- `cache_state` in IDLE/DONE is 0.

## Timing
- Reset values, asserted immediately and asynchronously:
  - state IDLE;
  - `mem_idx`, `cache_addr`, `cache_state`, `busy`, `done` = 0;
  - all counters 0.
- Reset mid-replay aborts immediately with no `done` pulse. The replay resumes only on a new `start` after reset deasserts.
- Per-reference latency is 3 cycles (FETCH, SEARCH, UPDATE) with `hold` low.
- `start` accepted at edge 0:
  - `busy` is high for cycles 1 to 3N.
  - `done` is high in cycle 3N+1.
  - `busy` and `done` are never high together.
- `trace_len`=0: `done` is high in cycle 1, `busy` never rises, and all counts are 0.
- Each `hold` cycle extends the total by exactly one cycle.
- Invariant in DONE: `hit_count`+`miss_count` == `ref_count`, absent saturation.

## Test plan
- Reset then `start` with `trace_len`=4, cache model hits on references 1 and 3 → `done` in cycle 13; counts ref=4, hit=2, miss=2; `cache_state` pattern 0,1 per reference.
- `trace_len`=0 → `done` one cycle after `start`, `busy` stays 0, all counts 0.
- `trace_len`=3 with `hold` high for 2 cycles during the second SEARCH → `done` in cycle 12; the held reference is counted exactly once.
- `start` re-pulsed mid-replay with `trace_len`=2 → ignored; the original length completes and counts are unchanged by the pulse.
- `rst` asserted in the UPDATE of reference 2 of 5 → all outputs 0 in the same cycle, no `done`; a new `start` with length 2 gives ref=2.
- CNT_W=4, 20 references, all hits → `hit_count`=15, `ref_count`=15, `miss_count`=0 (saturated, no wrap).
